exception_ctrl: RTL and testbench
=================================

# exception_ctrl

Sequential exception controller for the MIPS pipeline. It takes the combinational exception/cause/EPC outputs of the exception detector and captures them into Cause/EPC/Status registers. It then flushes the pipeline for a fixed number of cycles, redirects fetch to the handler vector, and returns to EPC on ERET. It sits between the EX-stage exception detector and the PC-select/pipeline-register flush controls, and also serves MTC0/MFC0 accesses to those three registers.

## Interface
- VECTOR_ADDR, 32'h0000_8000: handler entry address.
- FLUSH_CYCLES, 2: cycles of flush before the redirect; legal range 1–15.

- clk  in  1  pipeline clock
- reset  in  1  synchronous, active-high
- exception  in  1  exception request from detector, valid for the cycle it is high
- causeIn  in  32  detector cause word; only bits [2:0] used
- epcIn  in  32  detector EPC (address of faulting instruction)
- eret  in  1  ERET decoded, one-cycle pulse
- cp0Write  in  1  MTC0 strobe
- cp0Addr  in  5  CP0 register number: 12 Status, 13 Cause, 14 EPC
- cp0WData  in  32  MTC0 data
- cp0RData  out  32  MFC0 data, combinational from cp0Addr; 0 for unmapped numbers
- flush  out  1  kill IF/ID/EX pipeline registers
- stallPc  out  1  hold PC
- pcRedirect  out  1  PC mux selects pcTarget
- pcTarget  out  32  redirect address
- epcReg  out  32  EPC register
- causeReg  out  32  Cause register: [2:0] cause, [31] nested flag, other bits 0
- exl  out  1  exception level (Status[1]); Status reads {30'b0, exl, 1'b0}

## Operation
- States: IDLE, FLUSH, REDIRECT, HANDLER, RETURN. Reset state is IDLE.
- IDLE, exception=1: at the clock edge, capture epcReg<=epcIn, causeReg<={29'b0, causeIn[2:0]}, exl<=1, load the flush counter with FLUSH_CYCLES, go to FLUSH.
- IDLE, eret=1: no-op, because exl=0.
- FLUSH: flush=1, stallPc=1, counter decrements each cycle. Go to REDIRECT in the cycle the counter reaches 1.
- REDIRECT (1 cycle): flush=1, pcRedirect=1, pcTarget=VECTOR_ADDR. Then go to HANDLER.
- HANDLER: all control outputs are low.
  - eret=1: go to RETURN.
  - exception=1 without eret: set causeReg[31]=1 and stay in HANDLER. EPC and cause[2:0] are unchanged and there is no redirect.
  - exception and eret in the same cycle: eret wins, and causeReg[31] is still set.
- RETURN (1 cycle): flush=1, pcRedirect=1, pcTarget=epcReg, exl<=0. Then go to IDLE.
- Exceptions during FLUSH, REDIRECT or RETURN are ignored (those instructions are being flushed).
- MTC0 is accepted in any state.
  - Addr 12 writes exl<=cp0WData[1].
  - Addr 13 writes causeReg<={cp0WData[31], 28'b0, cp0WData[2:0]}.
  - Addr 14 writes epcReg<=cp0WData.
  - If an MTC0 and a hardware capture hit the same register in the same cycle, the hardware capture wins.
- Software advances EPC by 4 through MTC0 to skip the faulting instruction. The hardware never adjusts EPC.

## Timing
- Reset (any state, including mid-flush): state=IDLE, counter=0, epcReg=0, causeReg=0, exl=0, flush=0, stallPc=0, pcRedirect=0, pcTarget=0.
- pcTarget is 0 whenever pcRedirect=0.
- Control outputs are registered-state decodes: they are valid in the cycle after the capture edge and never combinational from `exception`.
- Exception sampled at edge N:
  - flush and stallPc are high for cycles N+1 … N+FLUSH_CYCLES.
  - REDIRECT occupies cycle N+FLUSH_CYCLES+1.
  - HANDLER starts at N+FLUSH_CYCLES+2.
- Total exception-to-vector latency is FLUSH_CYCLES+1 cycles.
- eret sampled at edge M in HANDLER: RETURN occupies cycle M+1, exl reads 0 from M+2, IDLE is entered at M+2.
- A new exception is accepted from cycle M+2 onward.
- cp0RData reflects register values as updated at the most recent edge; there is no write-through in the same cycle.

## Test plan
- Reset, then exception=1 with causeIn=3'b100 and epcIn=32'h0000_0040: epcReg=0x40, causeReg=0x4, exl=1; flush high for 2 cycles; then one cycle of pcRedirect=1 with pcTarget=0x8000; then all control outputs low.
- In HANDLER, MTC0 addr 14 data 0x44, then eret: one cycle of pcRedirect with pcTarget=0x44 and flush=1; then exl=0 and the state is IDLE.
- In HANDLER, exception and eret in the same cycle: causeReg[31]=1, return to EPC, epcReg unchanged.
- Exception asserted in FLUSH and in REDIRECT: the registers are unchanged and the sequence length is still FLUSH_CYCLES+1.
- Assert reset during the second FLUSH cycle: all outputs read 0 on the next cycle; a fresh exception afterwards runs the full sequence correctly.
- FLUSH_CYCLES=1 and FLUSH_CYCLES=15: redirect lands exactly at N+2 and N+16 respectively; MFC0 of addr 12 during HANDLER returns 0x2.

Source files
------------

// File: rtl/exception_ctrl_if.sv
// Signal bundle between the exception detector / decode stage, CP0 accessors and the
// exception controller that drives the pipeline flush and PC-select controls.
interface exception_ctrl_if;
  logic        exception;
  logic [31:0] causeIn;
  logic [31:0] epcIn;
  logic        eret;
  logic        cp0Write;
  logic [4:0]  cp0Addr;
  logic [31:0] cp0WData;
  logic [31:0] cp0RData;
  logic        flush;
  logic        stallPc;
  logic        pcRedirect;
  logic [31:0] pcTarget;
  logic [31:0] epcReg;
  logic [31:0] causeReg;
  logic        exl;

  modport master (
    output exception, causeIn, epcIn, eret, cp0Write, cp0Addr, cp0WData,
    input  cp0RData, flush, stallPc, pcRedirect, pcTarget, epcReg, causeReg, exl
  );

  modport slave (
    input  exception, causeIn, epcIn, eret, cp0Write, cp0Addr, cp0WData,
    output cp0RData, flush, stallPc, pcRedirect, pcTarget, epcReg, causeReg, exl
  );
endinterface

// File: rtl/exception_ctrl.sv
// Exception controller: captures Cause/EPC/Status, flushes the pipeline for a fixed number
// of cycles, redirects fetch to the handler vector and returns to EPC on ERET.
module exception_ctrl #(
  parameter logic [31:0] VECTOR_ADDR  = 32'h0000_8000,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic             clk,
  input  logic             reset,
  exception_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {StIdle, StFlush, StRedirect, StHandler, StReturn} state_e;

  localparam logic [3:0] FlushLoad = 4'(FLUSH_CYCLES);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] epc_q, epc_d;
  logic [31:0] cause_q, cause_d;
  logic        exl_q, exl_d;

  logic unused_cause_hi;
  assign unused_cause_hi = ^bus.causeIn[31:3];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      epc_q   <= 32'd0;
      cause_q <= 32'd0;
      exl_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      epc_q   <= epc_d;
      cause_q <= cause_d;
      exl_q   <= exl_d;
    end
  end

  // Software writes are applied first so that hardware updates below take priority.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    epc_d   = epc_q;
    cause_d = cause_q;
    exl_d   = exl_q;

    if (bus.cp0Write) begin
      case (bus.cp0Addr)
        5'd12:   exl_d   = bus.cp0WData[1];
        5'd13:   cause_d = {bus.cp0WData[31], 28'd0, bus.cp0WData[2:0]};
        5'd14:   epc_d   = bus.cp0WData;
        default: ;
      endcase
    end

    unique case (state_q)
      StIdle: begin
        if (bus.exception) begin
          epc_d   = bus.epcIn;
          cause_d = {29'd0, bus.causeIn[2:0]};
          exl_d   = 1'b1;
          cnt_d   = FlushLoad;
          state_d = StFlush;
        end
      end
      StFlush: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = StRedirect;
      end
      StRedirect: state_d = StHandler;
      StHandler: begin
        // A second exception inside the handler only marks nesting; EPC is preserved.
        if (bus.exception) cause_d[31] = 1'b1;
        if (bus.eret) state_d = StReturn;
      end
      StReturn: begin
        exl_d   = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    bus.flush      = 1'b0;
    bus.stallPc    = 1'b0;
    bus.pcRedirect = 1'b0;
    bus.pcTarget   = 32'd0;
    unique case (state_q)
      StFlush: begin
        bus.flush   = 1'b1;
        bus.stallPc = 1'b1;
      end
      StRedirect: begin
        bus.flush      = 1'b1;
        bus.pcRedirect = 1'b1;
        bus.pcTarget   = VECTOR_ADDR;
      end
      StReturn: begin
        bus.flush      = 1'b1;
        bus.pcRedirect = 1'b1;
        bus.pcTarget   = epc_q;
      end
      default: ;
    endcase
  end

  always_comb begin
    case (bus.cp0Addr)
      5'd12:   bus.cp0RData = {30'd0, exl_q, 1'b0};
      5'd13:   bus.cp0RData = cause_q;
      5'd14:   bus.cp0RData = epc_q;
      default: bus.cp0RData = 32'd0;
    endcase
  end

  assign bus.epcReg   = epc_q;
  assign bus.causeReg = cause_q;
  assign bus.exl      = exl_q;

endmodule

// File: tb/tb_exception_ctrl.sv
// Scoreboard bench: three controllers (flush lengths 2, 1, 15) share one stimulus stream and
// are compared each cycle against a timeline-based reference model.
`timescale 1ns/1ps
module tb_exception_ctrl;

  localparam int NDUT = 3;
  localparam logic [31:0] VEC = 32'h0000_8000;

  typedef struct packed {
    logic        flush;
    logic        stall;
    logic        redir;
    logic [31:0] target;
    logic [31:0] epc;
    logic [31:0] cause;
    logic        exl;
    logic [31:0] rdata;
  } obs_t;

  typedef enum int {PIdle, PFlush, PRedir, PHandler, PReturn} ph_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        exception = 1'b0;
  logic [31:0] causeIn = '0;
  logic [31:0] epcIn = '0;
  logic        eret = 1'b0;
  logic        cp0Write = 1'b0;
  logic [4:0]  cp0Addr = '0;
  logic [31:0] cp0WData = '0;

  obs_t obs [NDUT];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NDUT; g++) begin : gen_dut
    exception_ctrl_if bus ();
    assign bus.exception = exception;
    assign bus.causeIn   = causeIn;
    assign bus.epcIn     = epcIn;
    assign bus.eret      = eret;
    assign bus.cp0Write  = cp0Write;
    assign bus.cp0Addr   = cp0Addr;
    assign bus.cp0WData  = cp0WData;
    assign obs[g] = {bus.flush, bus.stallPc, bus.pcRedirect, bus.pcTarget, bus.epcReg,
                     bus.causeReg, bus.exl, bus.cp0RData};
    exception_ctrl #(
      .VECTOR_ADDR (VEC),
      .FLUSH_CYCLES((g == 0) ? 2 : (g == 1) ? 1 : 15)
    ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus.slave)
    );
  end

  // Reference model: registers plus the cycle indices of the accepted exception and eret.
  logic [31:0] m_epc   [NDUT];
  logic [31:0] m_cause [NDUT];
  logic        m_exl   [NDUT];
  int          exc_t   [NDUT];
  int          eret_t  [NDUT];
  int          now;
  obs_t        exp_q   [NDUT][$];
  int          checks;
  int          failures;

  function automatic int flen(int g);
    return (g == 0) ? 2 : (g == 1) ? 1 : 15;
  endfunction

  // Phase of the current cycle, derived from when the exception/eret were sampled.
  function automatic ph_t phase(int g);
    int k;
    if (exc_t[g] < 0) return PIdle;
    if (eret_t[g] >= 0) return (now == eret_t[g] + 1) ? PReturn : PIdle;
    k = now - exc_t[g];
    if (k <= flen(g)) return PFlush;
    if (k == flen(g) + 1) return PRedir;
    return PHandler;
  endfunction

  function automatic obs_t expect_now(int g, logic [4:0] addr);
    ph_t  p = phase(g);
    obs_t e = '0;
    e.flush  = (p == PFlush) || (p == PRedir) || (p == PReturn);
    e.stall  = (p == PFlush);
    e.redir  = (p == PRedir) || (p == PReturn);
    e.target = (p == PRedir) ? VEC : (p == PReturn) ? m_epc[g] : 32'd0;
    e.epc    = m_epc[g];
    e.cause  = m_cause[g];
    e.exl    = m_exl[g];
    if (addr == 5'd12)      e.rdata = {30'd0, m_exl[g], 1'b0};
    else if (addr == 5'd13) e.rdata = m_cause[g];
    else if (addr == 5'd14) e.rdata = m_epc[g];
    else                    e.rdata = 32'd0;
    return e;
  endfunction

  task automatic model_edge(int g);
    ph_t p = phase(g);
    if (reset) begin
      m_epc[g] = '0; m_cause[g] = '0; m_exl[g] = 1'b0; exc_t[g] = -1; eret_t[g] = -1;
      return;
    end
    if (cp0Write) begin
      if (cp0Addr == 5'd12)      m_exl[g]   = cp0WData[1];
      else if (cp0Addr == 5'd13) m_cause[g] = {cp0WData[31], 28'd0, cp0WData[2:0]};
      else if (cp0Addr == 5'd14) m_epc[g]   = cp0WData;
    end
    case (p)
      PIdle: if (exception) begin
        m_epc[g] = epcIn; m_cause[g] = {29'd0, causeIn[2:0]}; m_exl[g] = 1'b1;
        exc_t[g] = now; eret_t[g] = -1;
      end
      PHandler: begin
        if (exception) m_cause[g][31] = 1'b1;
        if (eret) eret_t[g] = now;
      end
      PReturn: begin
        m_exl[g] = 1'b0; exc_t[g] = -1; eret_t[g] = -1;
      end
      default: ;
    endcase
  endtask

  // Drive one cycle of inputs, queue the expected outputs for it, then advance the model.
  task automatic cyc(input logic exc, input logic [31:0] cin, input logic [31:0] ein,
                     input logic er, input logic wr, input logic [4:0] addr,
                     input logic [31:0] wd, input logic rst);
    exception = exc; causeIn = cin; epcIn = ein; eret = er;
    cp0Write = wr; cp0Addr = addr; cp0WData = wd; reset = rst;
    for (int g = 0; g < NDUT; g++) exp_q[g].push_back(expect_now(g, addr));
    for (int g = 0; g < NDUT; g++) model_edge(g);
    now++;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 5'(12 + (i % 3)), 0, 0);
  endtask

  initial begin
    forever begin
      @(negedge clk);
      for (int g = 0; g < NDUT; g++) begin
        if (exp_q[g].size() > 0) begin
          automatic obs_t e = exp_q[g].pop_front();
          checks++;
          if (obs[g] !== e) begin
            failures++;
            $display("FAIL outputs dut%0d (flush_len=%0d) t=%0t: got %h expected %h",
                     g, flen(g), $time, obs[g], e);
          end
        end
      end
    end
  end

  logic [4:0] addrs [5];

  initial begin
    addrs = '{5'd0, 5'd12, 5'd13, 5'd14, 5'd31};
    checks = 0; failures = 0; now = 0;
    for (int g = 0; g < NDUT; g++) begin
      m_epc[g] = '0; m_cause[g] = '0; m_exl[g] = 1'b0; exc_t[g] = -1; eret_t[g] = -1;
    end
    @(posedge clk);
    #1;
    cyc(0, 0, 0, 0, 0, 5'd12, 0, 1);
    cyc(0, 0, 0, 0, 0, 5'd13, 0, 1);
    idle(2);
    // Basic exception, then software bumps EPC and returns.
    cyc(1, 32'h4, 32'h40, 0, 0, 5'd14, 0, 0);
    idle(20);
    cyc(0, 0, 0, 0, 1, 5'd14, 32'h44, 0);
    cyc(0, 0, 0, 1, 0, 5'd12, 0, 0);
    idle(4);
    // Exception and eret together inside the handler.
    cyc(1, 32'h1, 32'h80, 0, 0, 5'd13, 0, 0);
    idle(20);
    cyc(1, 32'h2, 32'h90, 1, 0, 5'd13, 0, 0);
    idle(4);
    // Exceptions arriving during flush and redirect are ignored.
    cyc(1, 32'h5, 32'h100, 0, 0, 5'd13, 0, 0);
    idle(1);
    cyc(1, 32'h6, 32'h200, 0, 0, 5'd14, 0, 0);
    cyc(1, 32'h3, 32'h300, 0, 0, 5'd13, 0, 0);
    idle(20);
    cyc(0, 0, 0, 1, 0, 5'd12, 0, 0);
    idle(3);
    // Reset in the second flush cycle, then a fresh exception.
    cyc(1, 32'h7, 32'h340, 0, 0, 5'd14, 0, 0);
    idle(1);
    cyc(0, 0, 0, 0, 0, 5'd12, 0, 1);
    idle(3);
    cyc(1, 32'h1, 32'h400, 0, 0, 5'd14, 0, 0);
    idle(20);
    cyc(0, 0, 0, 1, 0, 5'd12, 0, 0);
    idle(3);
    for (int i = 0; i < 3000; i++) begin
      automatic logic       wr   = ($urandom_range(0, 11) == 0);
      automatic logic [4:0] addr = wr ? addrs[$urandom_range(1, 4)] : addrs[$urandom_range(0, 4)];
      cyc(($urandom_range(0, 4) == 0), $urandom, $urandom, ($urandom_range(0, 5) == 0),
          wr, addr, $urandom, ($urandom_range(0, 255) == 0));
    end
    idle(2);
    @(negedge clk);
    #1;
    for (int g = 0; g < NDUT; g++) begin
      checks++;
      if (exp_q[g].size() != 0) begin
        failures++;
        $display("FAIL drain dut%0d: got %0d pending expected 0", g, exp_q[g].size());
      end
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
